// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
//   Elastic, in-order add/subtract pipeline with optional saturation and an
//   overflow-event counter.  The arithmetic is evaluated once, in DW+1 bits,
//   as an operation is accepted into the first stage.  The remaining stages
//   only carry the result towards the output.
//
// Parameters
//   DW      operand/result width in bits (>= 2)
//   STAGES  register stages from accept to output (>= 1)
//   CW      overflow-event counter width
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   valid_i    input operation valid
//   ready_o    block can accept an operation this cycle
//   opcode_i   [1:0] = {sub, signed}, [2] = saturate
//   data0_i    operand A
//   data1_i    operand B
//   valid_o    result valid
//   ready_i    downstream accepts the result
//   result_o   result
//   ovf_o      carry / borrow / signed overflow of the result
//   sat_o      result was clamped
//   clr_cnt_i  clear the overflow counter
//   ovf_cnt_o  number of delivered results with ovf_o=1 (saturating)
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int DW     = 32,
    parameter int STAGES = 2,
    parameter int CW     = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [2:0]    opcode_i,
    input  logic [DW-1:0] data0_i,
    input  logic [DW-1:0] data1_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] result_o,
    output logic          ovf_o,
    output logic          sat_o,
    input  logic          clr_cnt_i,
    output logic [CW-1:0] ovf_cnt_o
);

    // Per-stage contents; index 0 is the stage fed from the input.
    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] ovf_r;
    logic [STAGES-1:0] sat_r;
    logic [DW-1:0]     res_r [STAGES];

    // A stage may load when it is empty or its contents move on this cycle.
    logic [STAGES-1:0] load_s;
    logic              next_ok_s;

    // First-stage arithmetic.
    logic [DW:0]       a_ext_s;
    logic [DW:0]       b_ext_s;
    logic [DW:0]       sum_s;
    logic              calc_ovf_s;
    logic              calc_sat_s;
    logic [DW-1:0]     clamp_s;
    logic [DW-1:0]     calc_res_s;

    logic              out_hs_s;

    // Operand extension, add/sub, overflow detection and clamping.
    always_comb begin
        a_ext_s    = {1'b0, data0_i};
        b_ext_s    = {1'b0, data1_i};
        sum_s      = {(DW+1){1'b0}};
        calc_ovf_s = 1'b0;
        clamp_s    = {DW{1'b0}};
        calc_sat_s = 1'b0;
        calc_res_s = {DW{1'b0}};

        if (opcode_i[0]) begin
            a_ext_s = {data0_i[DW-1], data0_i};
            b_ext_s = {data1_i[DW-1], data1_i};
        end else begin
            a_ext_s = {1'b0, data0_i};
            b_ext_s = {1'b0, data1_i};
        end

        if (opcode_i[1]) begin
            sum_s = a_ext_s - b_ext_s;
        end else begin
            sum_s = a_ext_s + b_ext_s;
        end

        // Signed: the extra bit is the true sign and differs from bit DW-1
        // on overflow.  Unsigned: bit DW is the carry, or the borrow (A<B)
        // for subtraction of zero-extended operands.
        if (opcode_i[0]) begin
            calc_ovf_s = sum_s[DW] ^ sum_s[DW-1];
        end else begin
            calc_ovf_s = sum_s[DW];
        end

        case (opcode_i[1:0])
            2'b00:   clamp_s = {DW{1'b1}};
            2'b10:   clamp_s = {DW{1'b0}};
            default: begin
                if (sum_s[DW]) begin
                    clamp_s = {1'b1, {(DW-1){1'b0}}};
                end else begin
                    clamp_s = {1'b0, {(DW-1){1'b1}}};
                end
            end
        endcase

        calc_sat_s = opcode_i[2] & calc_ovf_s;
        if (calc_sat_s) begin
            calc_res_s = clamp_s;
        end else begin
            calc_res_s = sum_s[DW-1:0];
        end
    end

    // Backpressure chain: walk from the output stage towards the input.
    always_comb begin
        load_s    = {STAGES{1'b0}};
        next_ok_s = ready_i;
        for (int i = STAGES - 1; i >= 0; i--) begin
            load_s[i] = !vld_r[i] || next_ok_s;
            next_ok_s = load_s[i];
        end
    end

    // Forced high in reset so the upstream never sees a stall from state
    // that is about to be cleared; handshakes in that cycle are discarded.
    assign ready_o  = rst_i | load_s[0];
    assign valid_o  = vld_r[STAGES-1];
    assign result_o = res_r[STAGES-1];
    assign ovf_o    = ovf_r[STAGES-1];
    assign sat_o    = sat_r[STAGES-1];
    assign out_hs_s = vld_r[STAGES-1] & ready_i;

    // Pipeline registers: stage 0 captures fresh results, others shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_r <= {STAGES{1'b0}};
            ovf_r <= {STAGES{1'b0}};
            sat_r <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                res_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (load_s[0]) begin
                vld_r[0] <= valid_i;
                if (valid_i) begin
                    res_r[0] <= calc_res_s;
                    ovf_r[0] <= calc_ovf_s;
                    sat_r[0] <= calc_sat_s;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load_s[i]) begin
                    vld_r[i] <= vld_r[i-1];
                    if (vld_r[i-1]) begin
                        res_r[i] <= res_r[i-1];
                        ovf_r[i] <= ovf_r[i-1];
                        sat_r[i] <= sat_r[i-1];
                    end
                end
            end
        end
    end

    // Overflow-event counter: saturating, clear has priority over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            ovf_cnt_o <= {CW{1'b0}};
        end else if (out_hs_s && ovf_r[STAGES-1] && (ovf_cnt_o != {CW{1'b1}})) begin
            ovf_cnt_o <= ovf_cnt_o + CW'(1);
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
//   Directed, self-checking bench for addsub_pipe with DW=8, STAGES=2, CW=2.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [2:0] opcode_i;
    logic [7:0] data0_i;
    logic [7:0] data1_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] result_o;
    logic       ovf_o;
    logic       sat_o;
    logic       clr_cnt_i;
    logic [1:0] ovf_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed vectors: {result, ovf, sat}.
    logic [2:0] v_op  [16];
    logic [7:0] v_a   [16];
    logic [7:0] v_b   [16];
    logic [9:0] v_exp [16];

    addsub_pipe #(.DW(8), .STAGES(2), .CW(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .opcode_i (opcode_i),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .ovf_o    (ovf_o),
        .sat_o    (sat_o),
        .clr_cnt_i(clr_cnt_i),
        .ovf_cnt_o(ovf_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] r,
                           input logic o, input logic s);
        v_op[i]  = op;
        v_a[i]   = a;
        v_b[i]   = b;
        v_exp[i] = {r, o, s};
    endtask

    task automatic load_vectors();
        set_vec( 0, 3'd1, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
        set_vec( 1, 3'd5, 8'h7F, 8'h01, 8'h7F, 1'b1, 1'b1);
        set_vec( 2, 3'd6, 8'h05, 8'h09, 8'h00, 1'b1, 1'b1);
        set_vec( 3, 3'd2, 8'h05, 8'h09, 8'hFC, 1'b1, 1'b0);
        set_vec( 4, 3'd5, 8'h80, 8'hFF, 8'h80, 1'b1, 1'b1);
        set_vec( 5, 3'd1, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0);
        set_vec( 6, 3'd0, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0);
        set_vec( 7, 3'd4, 8'hFF, 8'h02, 8'hFF, 1'b1, 1'b1);
        set_vec( 8, 3'd0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
        set_vec( 9, 3'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
        set_vec(10, 3'd7, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1);
        set_vec(11, 3'd7, 8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b1);
        set_vec(12, 3'd3, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0);
        set_vec(13, 3'd4, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
        set_vec(14, 3'd6, 8'h09, 8'h05, 8'h04, 1'b0, 1'b0);
        set_vec(15, 3'd7, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    endtask

    // Issue one operation into an empty pipe with ready_i=1; returns valid_o
    // one cycle after acceptance and {valid,result,ovf,sat} two cycles after,
    // then lets the result be consumed.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic early_v, output logic [10:0] got);
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        opcode_i = op;
        data0_i  = a;
        data1_i  = b;
        tick();
        valid_i  = 1'b0;
        opcode_i = 3'd4;
        data0_i  = 8'hA5;
        data1_i  = 8'h5A;
        early_v  = valid_o;
        tick();
        got = {valid_o, result_o, ovf_o, sat_o};
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; clr_cnt_i = 1'b0;
        opcode_i = 3'd0; data0_i = 8'h00; data1_i = 8'h00;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({valid_o, result_o, ovf_o, sat_o, ovf_cnt_o} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state got v=%b r=%h o=%b s=%b c=%0d want all 0",
                     valid_o, result_o, ovf_o, sat_o, ovf_cnt_o);
        end
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got %b want 1", ready_o);
        end
    endtask

    task automatic test_arith();
        logic        ev;
        logic [10:0] got;
        for (int i = 0; i < 16; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], ev, got);
            n_cmp++;
            if (ev !== 1'b0) begin
                n_err++;
                $display("FAIL latency_early[%0d] valid_o=%b want 0", i, ev);
            end
            n_cmp++;
            if (got !== {1'b1, v_exp[i]}) begin
                n_err++;
                $display("FAIL arith[%0d] op=%0d a=%h b=%h got {v,r,o,s}=%b_%h_%b_%b want 1_%h_%b_%b",
                         i, v_op[i], v_a[i], v_b[i], got[10], got[9:2], got[1], got[0],
                         v_exp[i][9:2], v_exp[i][1], v_exp[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   in_idx   = 0;
        int   out_idx  = 0;
        int   inflight = 0;
        int   cycles   = 0;
        logic hs_in;
        logic hs_out;
        logic prev_stall = 1'b0;
        logic [9:0] prev_val = 10'd0;
        while (out_idx < 16 && cycles < 300) begin
            ready_i = 1'($urandom_range(0, 1));
            valid_i = (in_idx < 16);
            if (in_idx < 16) begin
                opcode_i = v_op[in_idx];
                data0_i  = v_a[in_idx];
                data1_i  = v_b[in_idx];
            end else begin
                opcode_i = 3'd0;
                data0_i  = 8'hEE;
                data1_i  = 8'hEE;
            end
            #1;
            n_cmp++;
            if (ready_o !== !(inflight == 2 && !ready_i)) begin
                n_err++;
                $display("FAIL b2b_ready cyc=%0d got %b want %b (inflight=%0d ready_i=%b)",
                         cycles, ready_o, !(inflight == 2 && !ready_i), inflight, ready_i);
            end
            if (valid_o === 1'b1) begin
                n_cmp++;
                if ({result_o, ovf_o, sat_o} !== v_exp[out_idx]) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d] got %h_%b_%b want %h_%b_%b", out_idx,
                             result_o, ovf_o, sat_o, v_exp[out_idx][9:2],
                             v_exp[out_idx][1], v_exp[out_idx][0]);
                end
                if (prev_stall) begin
                    n_cmp++;
                    if ({result_o, ovf_o, sat_o} !== prev_val) begin
                        n_err++;
                        $display("FAIL b2b_hold got %h want %h", {result_o, ovf_o, sat_o}, prev_val);
                    end
                end
            end
            hs_in      = valid_i && ready_o;
            hs_out     = valid_o && ready_i;
            prev_stall = valid_o && !ready_i;
            prev_val   = {result_o, ovf_o, sat_o};
            @(posedge clk);
            #1;
            if (hs_in)  begin in_idx++;  inflight++; end
            if (hs_out) begin out_idx++; inflight--; end
            cycles++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        n_cmp++;
        if (out_idx != 16) begin
            n_err++;
            $display("FAIL b2b_timeout delivered %0d want 16", out_idx);
        end
        tick();
        tick();
    endtask

    task automatic test_counter();
        logic        ev;
        logic [10:0] got;
        logic [1:0]  want [5];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        n_cmp++;
        if (ovf_cnt_o !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_clear_init got %0d want 0", ovf_cnt_o);
        end
        for (int i = 0; i < 5; i++) begin
            run_op(3'd0, 8'hFF, 8'h02, ev, got);
            n_cmp++;
            if (ovf_cnt_o !== want[i]) begin
                n_err++;
                $display("FAIL cnt_seq[%0d] got %0d want %0d", i, ovf_cnt_o, want[i]);
            end
        end
        // Non-overflowing result must not count.
        run_op(3'd0, 8'h01, 8'h02, ev, got);
        n_cmp++;
        if (ovf_cnt_o !== 2'd3) begin
            n_err++;
            $display("FAIL cnt_no_ovf got %0d want 3", ovf_cnt_o);
        end
        // Clear coincident with an overflowing delivery.
        valid_i = 1'b1; opcode_i = 3'd0; data0_i = 8'hFF; data1_i = 8'h02; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        n_cmp++;
        if (ovf_cnt_o !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_clear_wins got %0d want 0", ovf_cnt_o);
        end
        tick();
        n_cmp++;
        if (ovf_cnt_o !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_after_clear got %0d want 0", ovf_cnt_o);
        end
    endtask

    task automatic test_reset_flush();
        logic        ev;
        logic [10:0] got;
        logic        stale;
        run_op(3'd0, 8'hFF, 8'h02, ev, got);
        ready_i = 1'b0;
        valid_i = 1'b1; opcode_i = 3'd1; data0_i = 8'h7F; data1_i = 8'h01;
        tick();
        tick();
        #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_full_ready got %b want 0", ready_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready_in_reset got %b want 1", ready_o);
        end
        tick();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        #1;
        n_cmp++;
        if ({valid_o, ovf_cnt_o, ready_o, result_o} !== {1'b0, 2'd0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL flush_after_reset got v=%b c=%0d rdy=%b r=%h want v=0 c=0 rdy=1 r=00",
                     valid_o, ovf_cnt_o, ready_o, result_o);
        end
        ready_i = 1'b1;
        stale   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid_o !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stale got valid_o=1 after reset want 0");
        end
    endtask

    initial begin
        load_vectors();
        test_reset();
        test_arith();
        test_back_to_back();
        test_counter();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning operand/result width in bits (DW >= 2).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning number of register stages from accept to output (STAGES >= 1).
REQ-003 The block SHALL have parameter CW, default 16, meaning overflow-event counter width.
REQ-004 The block SHALL have a single clock, clk_i, and a synchronous active-high reset, rst_i; these are already decided and SHALL be listed first in the port list.
REQ-005 The port list SHALL be:
  - clk_i  in  1  clock, rising edge
  - rst_i  in  1  synchronous active-high reset
  - valid_i  in  1  input operation valid
  - ready_o  out  1  block can accept input this cycle
  - opcode_i  in  3  operation select (REQ-009)
  - data0_i  in  DW  operand A
  - data1_i  in  DW  operand B
  - valid_o  out  1  result valid
  - ready_i  in  1  downstream accepts result
  - result_o  out  DW  result
  - ovf_o  out  1  overflow/carry/borrow flag of result
  - sat_o  out  1  result was clamped
  - clr_cnt_i  in  1  clear overflow counter
  - ovf_cnt_o  out  CW  count of delivered results with ovf_o=1

Function
REQ-006 An input SHALL be accepted on a rising edge with valid_i=1 and ready_o=1; an output SHALL be consumed on a rising edge with valid_o=1 and ready_i=1.
REQ-007 The pipeline SHALL be elastic: a stage loads when it is empty or its contents advance in the same cycle; ready_o = !stage1_valid || stage1 advances. ready_o SHALL depend combinationally on ready_i.
REQ-008 Latency SHALL be exactly STAGES cycles from acceptance to valid_o with ready_i held 1; sustained throughput SHALL be one result per cycle; no bubbles SHALL be inserted and results SHALL stay in order.
REQ-009 opcode_i SHALL decode as follows:
  - 0: unsigned add, wrap
  - 1: signed add, wrap
  - 2: unsigned sub A-B, wrap
  - 3: signed sub, wrap
  - 4-7: same operations as 0-3 respectively, but saturating
REQ-010 Arithmetic SHALL be computed in DW+1 bits and registered into stage 1; later stages SHALL only carry it.
REQ-011 ovf_o SHALL be the carry-out for unsigned add, the borrow (A<B) for unsigned sub, and two's-complement overflow for signed ops.
REQ-012 In saturating modes with ovf_o=1, the result SHALL clamp:
  - unsigned add: 2^DW-1
  - unsigned sub: 0
  - signed: +max if the true result is positive, -min if negative
  In this case sat_o=1; otherwise sat_o=0 and ovf_o is still reported.
REQ-013 While valid_o=1 and ready_i=0, result_o, ovf_o and sat_o SHALL hold stable and no accepted data SHALL be lost.
REQ-014 ovf_cnt_o SHALL increment by 1 on each output handshake with ovf_o=1 and saturate at 2^CW-1 (no wrap).
REQ-015 clr_cnt_i=1 SHALL set ovf_cnt_o to 0 next cycle; a coincident increment SHALL be discarded (clear wins).
REQ-016 Operands and opcode_i SHALL be ignored on cycles with no input handshake.

Reset
REQ-017 On rst_i=1 at a clock edge, the block SHALL clear all stage valid bits, result_o, ovf_o, sat_o and ovf_cnt_o to 0.
REQ-018 In-flight operations SHALL be discarded on reset, and valid_o SHALL be 0 in the cycle after reset.
REQ-019 During reset ready_o SHALL be 1 combinationally from the cleared state, but any input handshake in a reset cycle SHALL be discarded.

Verification
REQ-020 DW=8, STAGES=2: op1, A=0x7F, B=0x01 -> two cycles later result_o=0x80, ovf_o=1, sat_o=0; op5 with same operands -> result_o=0x7F, ovf_o=1, sat_o=1.
REQ-021 DW=8: op6, A=0x05, B=0x09 -> result_o=0x00, ovf_o=1, sat_o=1; op2 with same operands -> result_o=0xFC, ovf_o=1, sat_o=0.
REQ-022 Back-to-back stream of 16 ops with ready_i toggling randomly -> all 16 results delivered in order, values held while stalled, and ready_o=0 only when both stages are full and ready_i=0.
REQ-023 CW=2: 5 overflowing results delivered -> ovf_cnt_o sequence 1,2,3,3,3; then clr_cnt_i=1 concurrent with a delivered overflow -> ovf_cnt_o=0.
REQ-024 Assert rst_i with both stages full and ready_i=0 -> the next cycle has valid_o=0, ovf_cnt_o=0 and ready_o=1, and no stale result appears afterwards.
REQ-025 Signed add of -128+-1 (0x80+0xFF) with op7-equivalent add, op5 -> result_o=0x80, sat_o=1; op1 -> result_o=0x7F, ovf_o=1.
